// File: rtl/mat_accr_pkg.sv
// Shared definitions for the matrix accelerator result path: default widths,
// collector FSM state encoding and the buffered AXI-Stream beat layout.
package mat_accr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_RECV = 1'b1
    } c_state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with occupancy count, synchronous clear and a registered
// write-ready flag (high whenever the next cycle can take a beat).
module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   ready,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready_q;
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (clear) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign ready = ready_q;
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/axis_c_result_collector.sv
// Buffers the accelerator C stream, checks frame length against cfg_beats,
// re-emits it with a corrected TLAST and pulses frame-level status.
module axis_c_result_collector
    import mat_accr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_W-1:0]       cfg_beats,
    input  logic                   clear,
    input  logic                   s_axis_c_tvalid,
    output logic                   s_axis_c_tready,
    input  logic [DATA_W-1:0]      s_axis_c_tdata,
    input  logic                   s_axis_c_tlast,
    output logic                   m_axis_r_tvalid,
    input  logic                   m_axis_r_tready,
    output logic [DATA_W-1:0]      m_axis_r_tdata,
    output logic                   m_axis_r_tlast,
    output logic                   frame_done,
    output logic                   err_early_last,
    output logic                   err_missing_last,
    output logic [$clog2(DEPTH):0] fifo_level,
    output c_state_e               state_dbg
);

    // Both ports transfer on tvalid && tready; the source side offers tready
    // from a register, and anything presented while clear is high is dropped.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    c_state_e          state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  exp_beats_q, exp_beats_d;
    logic [CNT_W-1:0]  beat_idx;
    logic [CNT_W-1:0]  exp_use;
    logic              frame_end;
    logic              early;
    logic              missing;
    logic              s_fire;
    logic              m_fire;
    logic              fifo_ready;
    logic              fifo_empty;
    logic [DATA_W:0]   rd_entry;

    assign s_axis_c_tready = fifo_ready;
    assign s_fire          = s_axis_c_tvalid && fifo_ready && !clear;
    assign m_axis_r_tvalid = !fifo_empty && !clear;
    assign m_fire          = m_axis_r_tvalid && m_axis_r_tready;
    assign m_axis_r_tdata  = m_axis_r_tvalid ? rd_entry[DATA_W-1:0] : '0;
    assign m_axis_r_tlast  = m_axis_r_tvalid && rd_entry[DATA_W];
    assign state_dbg       = state_q;

    axis_sync_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .push (s_fire),
        .wdata({frame_end, s_axis_c_tdata}),
        .pop  (m_fire),
        .rdata(rd_entry),
        .ready(fifo_ready),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    // Frame-end decision for the beat currently offered; only committed on s_fire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_beats_d = exp_beats_q;
        early       = 1'b0;
        missing     = 1'b0;
        if (state_q == C_IDLE) begin
            beat_idx = CNT_W'(1);
            exp_use  = cfg_beats;
        end else begin
            beat_idx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            exp_use  = exp_beats_q;
        end
        if (exp_use == '0) begin
            frame_end = s_axis_c_tlast;
        end else begin
            frame_end = s_axis_c_tlast || (beat_idx == exp_use);
            early     = s_axis_c_tlast && (beat_idx < exp_use);
            missing   = !s_axis_c_tlast && (beat_idx == exp_use);
        end
        if (s_fire) begin
            if (state_q == C_IDLE) exp_beats_d = cfg_beats;
            if (frame_end) begin
                state_d = C_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = C_RECV;
                cnt_d   = beat_idx;
            end
        end
        if (clear) begin
            state_d     = C_IDLE;
            cnt_d       = '0;
            exp_beats_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= C_IDLE;
            cnt_q            <= '0;
            exp_beats_q      <= '0;
            frame_done       <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            exp_beats_q      <= exp_beats_d;
            frame_done       <= m_fire && rd_entry[DATA_W];
            err_early_last   <= s_fire && early;
            err_missing_last <= s_fire && missing;
        end
    end

endmodule

// File: tb/tb_axis_c_result_collector.sv
// Bench for axis_c_result_collector: vector table, fill/clear sequences and
// randomized frames scored against a frame-rule reference model.
module tb_axis_c_result_collector;
    import mat_accr_pkg::*;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_beats = '0;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          frame_done, err_early, err_missing;
    logic [4:0]    level;
    c_state_e      state_dbg;

    axis_c_result_collector #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clear(clear),
        .s_axis_c_tvalid(s_valid), .s_axis_c_tready(s_ready),
        .s_axis_c_tdata(s_data), .s_axis_c_tlast(s_last),
        .m_axis_r_tvalid(m_valid), .m_axis_r_tready(m_ready),
        .m_axis_r_tdata(m_data), .m_axis_r_tlast(m_last),
        .frame_done(frame_done), .err_early_last(err_early),
        .err_missing_last(err_missing), .fifo_level(level), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0: always ready, 1: stalled, 2: random 50%
    int rdy_mode = 0;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model and scoreboard
    logic [DW:0]   exp_q[$];
    logic [DW:0]   obs_q[$];
    int            obs_early = 0, obs_missing = 0, obs_done = 0;
    bit            pend_early = 0, pend_missing = 0, pend_done = 0;
    bit            mdl_in_frame = 0;
    int unsigned   mdl_k = 0;
    int unsigned   mdl_exp = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_early_last", err_early, pend_early);
            chk("err_missing_last", err_missing, pend_missing);
            chk("frame_done", frame_done, pend_done);
            pend_early = 0; pend_missing = 0; pend_done = 0;
            if (err_early)   obs_early++;
            if (err_missing) obs_missing++;
            if (frame_done)  obs_done++;
            if (clear) begin
                exp_q.delete();
                mdl_in_frame = 0;
                mdl_k = 0;
            end else begin
                if (m_valid && m_ready) begin
                    logic [DW:0] e;
                    obs_q.push_back({m_last, m_data});
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_data", m_data, e[DW-1:0]);
                        chk("r_last", m_last, e[DW]);
                        pend_done = e[DW];
                    end
                end
                if (s_valid && s_ready) begin
                    bit lst;
                    if (!mdl_in_frame) begin
                        mdl_exp = cfg_beats;
                        mdl_k = 1;
                    end else if (mdl_k < 65535) begin
                        mdl_k++;
                    end
                    if (mdl_exp == 0) begin
                        lst = s_last;
                    end else begin
                        lst = s_last || (mdl_k == mdl_exp);
                        pend_early   = s_last && (mdl_k < mdl_exp);
                        pend_missing = !s_last && (mdl_k == mdl_exp);
                    end
                    mdl_in_frame = !lst;
                    exp_q.push_back({lst, s_data});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int budget = 300;
        bit done = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = s_ready;
            cyc();
            budget--;
        end
        s_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int budget = 3000;
        while ((exp_q.size() != 0 || m_valid) && budget > 0) begin
            cyc();
            budget--;
        end
        if (budget == 0) chk("drain_timeout", 0, 1);
        repeat (3) cyc();
    endtask

    task automatic obs_reset();
        obs_q.delete();
        obs_early = 0; obs_missing = 0; obs_done = 0;
    endtask

    typedef struct {
        logic [CW-1:0] cfg;
        int            n;
        logic [7:0]    last_in;
        logic [DW-1:0] base;
        logic [7:0]    last_out;
        int            n_early;
        int            n_missing;
        int            n_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd4, 4, 8'b1000,  32'd0,  8'b1000,  0, 0, 1};
        vecs[1] = '{16'd4, 2, 8'b10,    32'd10, 8'b10,    1, 0, 1};
        vecs[2] = '{16'd2, 4, 8'b0,     32'd20, 8'b1010,  0, 2, 2};
        vecs[3] = '{16'd0, 5, 8'b10000, 32'd30, 8'b10000, 0, 0, 1};
        vecs[4] = '{16'd1, 3, 8'b0,     32'd40, 8'b111,   0, 3, 3};
        vecs[5] = '{16'd3, 4, 8'b1001,  32'd50, 8'b1001,  1, 0, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_ready, 0);
        chk("rst_m_tvalid", m_valid, 0);
        chk("rst_m_tdata", m_data, 0);
        chk("rst_m_tlast", m_last, 0);
        chk("rst_pulses", {frame_done, err_early, err_missing}, 0);
        chk("rst_level", level, 0);
        chk("rst_state", state_dbg, C_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_s_tready", s_ready, 1);

        // Table-driven frames
        rdy_mode = 0;
        for (int v = 0; v < 6; v++) begin
            obs_reset();
            cfg_beats = vecs[v].cfg;
            for (int i = 0; i < vecs[v].n; i++)
                send_beat(vecs[v].base + DW'(i), vecs[v].last_in[i]);
            wait_drain();
            chk($sformatf("v%0d_count", v), obs_q.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < obs_q.size(); i++) begin
                chk($sformatf("v%0d_data%0d", v, i), obs_q[i][DW-1:0], vecs[v].base + DW'(i));
                chk($sformatf("v%0d_last%0d", v, i), obs_q[i][DW], vecs[v].last_out[i]);
            end
            chk($sformatf("v%0d_early", v), obs_early, vecs[v].n_early);
            chk($sformatf("v%0d_missing", v), obs_missing, vecs[v].n_missing);
            chk($sformatf("v%0d_done", v), obs_done, vecs[v].n_done);
            chk($sformatf("v%0d_idle", v), state_dbg, C_IDLE);
        end

        // Fill against a stalled sink: 20 offered, only 16 fit
        begin
            int acc = 0;
            obs_reset();
            rdy_mode = 1;
            cfg_beats = '0;
            cyc();
            for (int c = 0; c < 30; c++) begin
                s_valid = 1'b1; s_data = 100 + acc; s_last = 1'b0;
                @(negedge clk);
                if (s_ready) acc++;
                cyc();
            end
            s_valid = 1'b0;
            @(negedge clk);
            chk("fill_accepted", acc, 16);
            chk("fill_level", level, 16);
            chk("fill_tready", s_ready, 0);
            chk("fill_tvalid", m_valid, 1);
            cyc();
            rdy_mode = 0;
            for (int i = acc; i < 20; i++) send_beat(100 + i, (i == 19));
            wait_drain();
            chk("fill_count", obs_q.size(), 20);
            for (int i = 0; i < 20 && i < obs_q.size(); i++)
                chk($sformatf("fill_order%0d", i), obs_q[i][DW-1:0], 100 + i);
            chk("fill_done", obs_done, 1);
        end

        // Clear mid-frame with five beats buffered
        obs_reset();
        rdy_mode = 1;
        cfg_beats = 16'd8;
        cyc();
        for (int i = 0; i < 5; i++) send_beat(200 + i, 1'b0);
        @(negedge clk);
        chk("clr_pre_level", level, 5);
        chk("clr_pre_state", state_dbg, C_RECV);
        cyc();
        clear = 1'b1; s_valid = 1'b1; s_data = 999; s_last = 1'b1;
        cyc();
        clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("clr_level", level, 0);
        chk("clr_state", state_dbg, C_IDLE);
        chk("clr_tvalid", m_valid, 0);
        chk("clr_pulses", {frame_done, err_early, err_missing}, 0);
        cyc();
        rdy_mode = 0;
        cfg_beats = 16'd2;
        send_beat(300, 1'b0);
        send_beat(301, 1'b1);
        wait_drain();
        chk("clr_post_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("clr_post_d0", obs_q[0], {1'b0, 32'd300});
            chk("clr_post_d1", obs_q[1], {1'b1, 32'd301});
        end
        chk("clr_post_errs", obs_early + obs_missing, 0);
        chk("clr_post_done", obs_done, 1);

        // Random: 100 frames, cfg_beats=4, random sink stalls and source gaps
        obs_reset();
        rdy_mode = 2;
        cfg_beats = 16'd4;
        for (int f = 0; f < 100; f++) begin
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic l = (i == len - 1) && ($urandom_range(0, 3) != 0);
                repeat ($urandom_range(0, 1)) cyc();
                send_beat($urandom, l);
            end
        end
        wait_drain();
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_fifo_empty", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
